// File: rtl/front_panel_leds.sv
// Serialises the CPU monitor bus into a five-deep '595 chain for the front-panel LEDs.
// A frame is a 40-bit snapshot shifted MSB-first, then latched, then the block idles until the refresh timer expires.
module front_panel_leds #(
  parameter int CLK_DIV = 4,
  parameter int REFRESH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mon_addr,
  input  logic [7:0]  mon_data,
  input  logic [7:0]  mon_sysctl,
  input  logic        mon_wait,
  input  logic        mon_hlda,
  input  logic        mon_inte,
  output logic        sr_clk,
  output logic        sr_data,
  output logic        sr_latch,
  output logic        busy,
  output logic        frame_done
);

  localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TmrW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [TmrW-1:0] TmrReload = TmrW'(REFRESH - 1);
  localparam logic [5:0]      TopBit    = 6'd39;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [TmrW-1:0] timer;
  logic [DivW-1:0] div;
  logic [5:0]      idx;
  logic [39:0]     shreg;
  logic [39:0]     frame;
  logic            div_last;
  logic            load;

  assign frame    = {5'b00000, mon_inte, mon_hlda, mon_wait, mon_sysctl, mon_data, mon_addr};
  assign div_last = (div == DivLast);
  assign load     = (state == IDLE) && (timer == '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (timer == '0) state_n = SHIFT_LO;
      SHIFT_LO: if (div_last) state_n = SHIFT_HI;
      SHIFT_HI: if (div_last) state_n = (idx == 6'd0) ? LATCH : SHIFT_LO;
      LATCH:    if (div_last) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      div   <= '0;
      idx   <= TopBit;
      shreg <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) div <= '0;
      else                  div <= div + 1'b1;

      if (load)               timer <= TmrReload;
      else if (timer != '0)   timer <= timer - 1'b1;

      if (load) begin
        shreg <= frame;
        idx   <= TopBit;
      end else if ((state == SHIFT_HI) && div_last && (idx != 6'd0)) begin
        idx <= idx - 1'b1;
      end
    end
  end

  // Outputs are a registered decode of the current state, so every pin lags the state by one clk
  // and sr_data only moves while sr_clk is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_clk     <= 1'b0;
      sr_data    <= 1'b0;
      sr_latch   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sr_clk     <= (state == SHIFT_HI);
      sr_latch   <= (state == LATCH);
      busy       <= (state != IDLE);
      frame_done <= (state == IDLE) && sr_latch;
      if (state == SHIFT_LO) sr_data <= shreg[idx];
    end
  end

endmodule

// File: doc/front_panel_leds.md
# front_panel_leds

Serialises the Altair core's monitor bus (mon_addr, mon_data, mon_sysctl, mon_wait, mon_hlda, mon_inte) into a daisy-chain of five 74HC595-style shift registers that drive the front-panel LEDs. The block is the downstream consumer of the system top's monitor outputs. It snapshots all monitor signals at the start of each frame and shifts them out MSB-first. It then pulses a storage latch and waits for a programmable refresh interval before starting the next frame.

## Interface
- CLK_DIV, 4: clk cycles per half-period of sr_clk; also the sr_latch pulse width. Legal range is 1 or more.
- REFRESH, 1024: clk cycles between frame starts, measured from one LOAD to the next.
- clk  in  1  system clock; the same clk that feeds the CPU core.
- reset  in  1  reset; asynchronous, active-high.
- mon_addr  in  16  CPU address bus.
- mon_data  in  8  CPU input data bus.
- mon_sysctl  in  8  latched status byte.
- mon_wait  in  1  CPU WAIT.
- mon_hlda  in  1  CPU HLDA.
- mon_inte  in  1  CPU INTE.
- sr_clk  out  1  shift clock to the '595 chain (SRCLK).
- sr_data  out  1  serial data to the '595 chain (SER).
- sr_latch  out  1  storage latch strobe (RCLK).
- busy  out  1  high while a frame is in progress, in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- Frame word, 40 bits: frame = {5'b00000, mon_inte, mon_hlda, mon_wait, mon_sysctl, mon_data, mon_addr}. frame[39] is shifted first and frame[0] (addr[0]) is shifted last.
- State machine states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- **IDLE**
  - When timer == 0: capture frame from the live inputs into the shift register, set bit index to 39, reload timer to REFRESH-1, and go to SHIFT_LO.
- **SHIFT_LO**
  - sr_clk=0, sr_data = shift register bit at index.
  - Hold for CLK_DIV cycles, then go to SHIFT_HI.
- **SHIFT_HI**
  - sr_clk=1 and sr_data is held.
  - Hold for CLK_DIV cycles.
  - If index==0, go to LATCH; otherwise decrement index and go to SHIFT_LO.
- **LATCH**
  - sr_clk=0, sr_latch=1, hold for CLK_DIV cycles.
  - Then go to IDLE with frame_done=1 for exactly that one cycle and sr_latch=0.
- Refresh timer:
  - Decrements every clk cycle in all states and saturates at 0.
  - Its width is $clog2(REFRESH) bits, minimum 1.
- Input changes after the capture have no effect until the next frame.
- If REFRESH is at most the frame length, the timer is already 0 on return to IDLE. Frames then run back-to-back with exactly one IDLE cycle between them.
- The divider counter has $clog2(CLK_DIV) bits, minimum 1, and is cleared on every state change.

## Timing
- Reset values, applied asynchronously:
  - State = IDLE, timer = 0, index = 39, divider = 0, shift register = 0.
  - sr_clk=0, sr_data=0, sr_latch=0, busy=0, frame_done=0.
- The first LOAD happens on the first clk edge after reset deasserts; busy goes high on the following cycle.
- All outputs are registered; there are no combinational paths from the inputs to the outputs.
- sr_data changes only on the cycle where sr_clk goes (or stays) low. This gives CLK_DIV cycles of setup before the sr_clk rising edge and CLK_DIV cycles of hold after it.
- Frame duration with busy high = 80*CLK_DIV + CLK_DIV = 81*CLK_DIV cycles. With the default CLK_DIV=4 this is 324 cycles.
- The LOAD-to-LOAD period is max(REFRESH, 81*CLK_DIV+1) cycles.
- sr_latch never overlaps sr_clk=1.
- Reset asserted mid-frame aborts the frame immediately:
  - Outputs return to their reset values.
  - No sr_latch and no frame_done are produced for the aborted frame.

## Test plan
- **Reset:** assert reset mid-simulation -> all five outputs are 0 in the same cycle; after release, busy=1 exactly two clk edges later.
- **Frame content:**
  - Stimulus: CLK_DIV=4, mon_addr=16'h1234, mon_data=8'hA5, mon_sysctl=8'hA2, wait=1, hlda=0, inte=1.
  - Response: a bench model of the '595 chain captures 40'h05A2A51234 on the sr_latch rise; sr_latch is high for 4 cycles; frame_done pulses once.
- **Input freeze:** change mon_addr to 16'hFFFF at bit index 20 -> the frame in progress still delivers 40'h05A2A51234; the next frame carries the new address.
- **Refresh spacing:**
  - With CLK_DIV=4 and REFRESH=1024: LOAD-to-LOAD is 1024 cycles and busy is high for 324 cycles.
  - With REFRESH=10: frames are back-to-back with busy low for exactly 1 cycle between them.
- **Reset mid-frame:** assert reset at bit index 20 -> no latch pulse occurs; after release, the next frame starts at bit 39 and completes a full 40-bit transfer.
- **Minimum divider:** CLK_DIV=1 -> sr_clk toggles every cycle, the frame is 81 cycles, the chain contents are correct, and sr_data is stable across each sr_clk rising edge.
